// File: rtl/bit_length_scan.sv
// rtl/bit_length_scan.sv - MSB-first chunked bit-length finder for RSA operands
//
// Purpose
//   Finds the index of the most significant set bit of a WIDTH-bit operand by
//   examining STEP bits per cycle from the top. The default build stops at the
//   first nonzero chunk.
//
// Optional feature macro: BITLEN_POPCNT_EN
//   Adds a popcnt output and a per-chunk population-count accumulator. Every
//   chunk is visited, so latency is fixed at WIDTH/STEP+1 edges. length/zero
//   results are the same as in the default build.
//
// Ports
//   clk     in   1      clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   start   in   1      scan request, sampled only in IDLE
//   in      in   WIDTH  operand, captured on the accepted start edge
//   busy    out  1      high in SCAN and DONE
//   done    out  1      one-cycle pulse, length/zero valid
//   length  out  LEN_W  index of highest set bit, all ones when operand is 0
//   zero    out  1      operand was 0
//   popcnt  out  LEN_W  set-bit count (BITLEN_POPCNT_EN only)

module bit_length_scan #(
    parameter  int WIDTH = 64,
    parameter  int STEP  = 4,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] length,
    output logic             zero
`ifdef BITLEN_POPCNT_EN
    ,
    output logic [LEN_W-1:0] popcnt
`endif
);

    localparam int NCHUNK = WIDTH / STEP;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // The operand is shifted left one chunk per SCAN cycle, so the chunk
    // under test is always the top STEP bits; r_idx tracks which chunk that is.
    logic [WIDTH-1:0] r_data;
    logic [IDX_W-1:0] r_idx;
    logic [LEN_W-1:0] r_len;
    logic             r_zero;

    logic [STEP-1:0]  w_chunk;
    logic             w_nz;
    logic             w_last;
    logic [LEN_W-1:0] w_msb;
    logic [LEN_W-1:0] w_len;

`ifdef BITLEN_POPCNT_EN
    logic [LEN_W-1:0] r_pc_acc;
    logic [LEN_W-1:0] r_popcnt;
    logic             r_found;
    logic [LEN_W-1:0] r_len_found;
    logic [LEN_W-1:0] w_chunk_pc;
    logic [LEN_W-1:0] w_pc_nxt;
`endif

    assign w_chunk = r_data[WIDTH-1 -: STEP];
    assign w_nz    = |w_chunk;
    assign w_last  = (r_idx == '0);

    // Highest set bit inside the chunk; later iterations override earlier ones.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < STEP; i++) begin
            if (w_chunk[i]) begin
                w_msb = LEN_W'(i);
            end
        end
    end

    assign w_len = LEN_W'(r_idx) * LEN_W'(STEP) + w_msb;

`ifdef BITLEN_POPCNT_EN
    always_comb begin
        w_chunk_pc = '0;
        for (int i = 0; i < STEP; i++) begin
            w_chunk_pc = w_chunk_pc + LEN_W'(w_chunk[i]);
        end
    end

    assign w_pc_nxt = r_pc_acc + w_chunk_pc;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
`ifdef BITLEN_POPCNT_EN
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
`else
                if (w_nz || w_last) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_idx       <= '0;
            r_len       <= '1;
            r_zero      <= 1'b0;
`ifdef BITLEN_POPCNT_EN
            r_pc_acc    <= '0;
            r_popcnt    <= '0;
            r_found     <= 1'b0;
            r_len_found <= '1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // length/zero are deliberately left holding the previous
                    // result until the scan finishes.
                    if (start) begin
                        r_data      <= in;
                        r_idx       <= IDX_W'(NCHUNK - 1);
`ifdef BITLEN_POPCNT_EN
                        r_pc_acc    <= '0;
                        r_found     <= 1'b0;
                        r_len_found <= '1;
`endif
                    end
                end
                S_SCAN: begin
`ifdef BITLEN_POPCNT_EN
                    // The first nonzero chunk fixes length; the scan keeps
                    // going so the population count covers all chunks.
                    if (!r_found && w_nz) begin
                        r_found     <= 1'b1;
                        r_len_found <= w_len;
                    end
                    if (w_last) begin
                        r_popcnt <= w_pc_nxt;
                        r_zero   <= !r_found && !w_nz;
                        if (r_found) begin
                            r_len <= r_len_found;
                        end else if (w_nz) begin
                            r_len <= w_len;
                        end else begin
                            r_len <= '1;
                        end
                    end else begin
                        r_pc_acc <= w_pc_nxt;
                        r_data   <= r_data << STEP;
                        r_idx    <= r_idx - IDX_W'(1);
                    end
`else
                    if (w_nz) begin
                        r_len  <= w_len;
                        r_zero <= 1'b0;
                    end else if (w_last) begin
                        r_len  <= '1;
                        r_zero <= 1'b1;
                    end else begin
                        r_data <= r_data << STEP;
                        r_idx  <= r_idx - IDX_W'(1);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign length = r_len;
    assign zero   = r_zero;
`ifdef BITLEN_POPCNT_EN
    assign popcnt = r_popcnt;
`endif

endmodule

// File: tb/tb_bit_length_scan.sv
// tb/tb_bit_length_scan.sv - self-checking bench for bit_length_scan (WIDTH=64, STEP=4)

module tb_bit_length_scan;

    localparam int WIDTH  = 64;
    localparam int STEP   = 4;
    localparam int LEN_W  = 7;
    localparam int NCHUNK = WIDTH / STEP;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in_v;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] length;
    logic             zero;
`ifdef BITLEN_POPCNT_EN
    logic [LEN_W-1:0] popcnt;
`endif

    int n_assert;
    int n_fail;
    int n_done_pulses;

    bit_length_scan #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_v),
        .busy   (busy),
        .done   (done),
        .length (length),
        .zero   (zero)
`ifdef BITLEN_POPCNT_EN
        ,
        .popcnt (popcnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result of a scan from plain arithmetic on the operand, released
    // k+1 edges after the sampling edge (sampling edge counted as edge 1).
    function automatic int highest_bit(input logic [WIDTH-1:0] v);
        int h;
        h = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) h = i;
        end
        return h;
    endfunction

    function automatic int chunks_examined(input logic [WIDTH-1:0] v);
`ifdef BITLEN_POPCNT_EN
        return NCHUNK;
`else
        int h;
        h = highest_bit(v);
        if (h < 0) return NCHUNK;
        return NCHUNK - h / STEP;
`endif
    endfunction

    logic             m_busy;
    logic             m_done;
    logic [LEN_W-1:0] m_len;
    logic             m_zero;
    logic [LEN_W-1:0] m_pc;
    int               m_cnt;
    int               m_k;
    logic [LEN_W-1:0] p_len;
    logic             p_zero;
    logic [LEN_W-1:0] p_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_len  = '1;
            m_zero = 1'b0;
            m_pc   = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == m_k + 1) begin
                    m_done = 1'b1;
                    m_len  = p_len;
                    m_zero = p_zero;
                    m_pc   = p_pc;
                end else if (m_cnt > m_k + 1) begin
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = 1;
                m_k    = chunks_examined(in_v);
                p_zero = (highest_bit(in_v) < 0);
                p_len  = p_zero ? '1 : LEN_W'(highest_bit(in_v));
                p_pc   = LEN_W'($countones(in_v));
            end
        end
    end

    always @(posedge clk) begin
        if (done) n_done_pulses++;
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("length", 64'(length), 64'(m_len));
            chk("zero", 64'(zero), 64'(m_zero));
`ifdef BITLEN_POPCNT_EN
            chk("popcnt", 64'(popcnt), 64'(m_pc));
`endif
        end
    end

    // One scan: start at a negedge, count edges from the sampling edge until
    // done is seen. With poke set, start is re-asserted while busy and during DONE.
    task automatic run_scan(input logic [WIDTH-1:0] v, input bit poke,
                            output int lat, output logic [LEN_W-1:0] l, output logic z);
        @(negedge clk);
        start = 1'b1;
        in_v  = v;
        lat   = 0;
        do begin
            @(posedge clk);
            #2;
            lat++;
            in_v  = {$urandom, $urandom};
            start = poke && (lat >= 3) && (lat <= 5);
        end while (!done && lat < 100);
        if (!done) chk("timeout", 64'(lat), 64'(0));
        l = length;
        z = zero;
        start = poke;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    int               lat;
    logic [LEN_W-1:0] l;
    logic             z;
    int               pulses0;

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        n_done_pulses = 0;
        rst   = 1'b1;
        start = 1'b0;
        in_v  = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_length", 64'(length), 64'h7F);
        chk("rst_zero", 64'(zero), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_scan(64'h1, 1'b0, lat, l, z);
        chk("t1_length", 64'(l), 64'd0);
        chk("t1_zero", 64'(z), 64'd0);
        chk("t1_latency", 64'(lat), 64'd17);

        run_scan(64'h8000_0000_0000_0000, 1'b0, lat, l, z);
        chk("t2_length", 64'(l), 64'd63);
`ifndef BITLEN_POPCNT_EN
        chk("t2_latency", 64'(lat), 64'd2);
`endif

        pulses0 = n_done_pulses;
        run_scan(64'h0, 1'b0, lat, l, z);
        repeat (3) @(posedge clk);
        chk("t3_length", 64'(l), 64'h7F);
        chk("t3_zero", 64'(z), 64'd1);
        chk("t3_latency", 64'(lat), 64'd17);
        chk("t3_pulses", 64'(n_done_pulses - pulses0), 64'd1);

        run_scan(64'h0000_0000_0001_0F00, 1'b0, lat, l, z);
        chk("t4_length", 64'(l), 64'd16);
        chk("t4_zero", 64'(z), 64'd0);
`ifndef BITLEN_POPCNT_EN
        chk("t4_latency", 64'(lat), 64'd13);
`endif
        run_scan(64'h20, 1'b0, lat, l, z);
        chk("t4b_length", 64'(l), 64'd5);

        run_scan(64'h0000_0400_0000_0000, 1'b1, lat, l, z);
        chk("t5_length", 64'(l), 64'd42);
        repeat (2) @(posedge clk);
        #2;
        chk("t5_hold", 64'(length), 64'd42);
        chk("t5_idle", 64'(busy), 64'd0);

        @(negedge clk);
        start = 1'b1;
        in_v  = 64'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_length", 64'(length), 64'h7F);
        chk("t5_rst_zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(64'h0000_0000_0000_0300, 1'b0, lat, l, z);
        chk("t5_after_length", 64'(l), 64'd9);

`ifdef BITLEN_POPCNT_EN
        run_scan(64'hF0, 1'b0, lat, l, z);
        chk("t6_length", 64'(l), 64'd7);
        chk("t6_popcnt", 64'(popcnt), 64'd4);
        chk("t6_latency", 64'(lat), 64'd17);
        run_scan(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, l, z);
        chk("t6b_length", 64'(l), 64'd63);
        chk("t6b_popcnt", 64'(popcnt), 64'd64);
        chk("t6b_latency", 64'(lat), 64'd17);
`endif

        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
